// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: control, divisor-write and output bundle of the divider bank
interface clk_div_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 22,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0] en;
  logic sync;
  logic wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [WIDTH-1:0] wr_div;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] stb;
  logic [CHANNELS-1:0] pending;
  modport master (output en, sync, wr_en, wr_ch, wr_div, input clk_out, stb, pending);
  modport slave (input en, sync, wr_en, wr_ch, wr_div, output clk_out, stb, pending);
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of square-wave dividers with shadowed divisors applied at terminal count
module clk_div_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 22,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic clk_in,
  input logic rst,
  clk_div_bank_if.slave bus
);
  logic [WIDTH-1:0] act [CHANNELS];
  logic [WIDTH-1:0] shd [CHANNELS];
  logic [WIDTH-1:0] cnt [CHANNELS];
  logic [CHANNELS-1:0] clk_q, stb_q, pend_q;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        act[i] <= '0;
        shd[i] <= '0;
        cnt[i] <= '0;
      end
      clk_q <= '0;
      stb_q <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.sync || !bus.en[i]) begin
          cnt[i] <= '0;
          clk_q[i] <= 1'b0;
          stb_q[i] <= 1'b0;
          if (pend_q[i]) act[i] <= shd[i];
          pend_q[i] <= 1'b0;
        end else if (cnt[i] == act[i]) begin
          cnt[i] <= '0;
          clk_q[i] <= ~clk_q[i];
          stb_q[i] <= 1'b1;
          if (pend_q[i]) act[i] <= shd[i];
          pend_q[i] <= 1'b0;
        end else begin
          cnt[i] <= cnt[i] + WIDTH'(1);
          stb_q[i] <= 1'b0;
        end
        // a write lands last so it re-arms PENDING even when the old shadow was just consumed
        if (bus.wr_en && bus.wr_ch == CH_W'(i)) begin
          shd[i] <= bus.wr_div;
          pend_q[i] <= 1'b1;
        end
      end
    end
  assign bus.clk_out = clk_q;
  assign bus.stb = stb_q;
  assign bus.pending = pend_q;
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: scoreboarded cycle checks plus directed checks of each divider scenario
module tb_clk_div_bank;
  localparam int CH = 4;
  localparam int W = 4;
  localparam int CW = 3;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  clk_div_bank_if #(.CHANNELS(CH), .WIDTH(W), .CH_W(CW)) bus ();
  clk_div_bank #(.CHANNELS(CH), .WIDTH(W), .CH_W(CW)) dut (.clk_in(clk_in), .rst(rst), .bus(bus));
  always #5 clk_in = ~clk_in;
  typedef struct packed {
    logic [CH-1:0] clk;
    logic [CH-1:0] stb;
    logic [CH-1:0] pend;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_act [CH];
  logic [W-1:0] m_shd [CH];
  logic [W-1:0] m_cnt [CH];
  logic [CH-1:0] m_clk, m_stb, m_pend;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_act[i] = '0;
      m_shd[i] = '0;
      m_cnt[i] = '0;
    end
    m_clk = '0;
    m_stb = '0;
    m_pend = '0;
  endtask

  task automatic model_step();
    for (int i = 0; i < CH; i++) begin
      if (bus.sync || !bus.en[i]) begin
        if (m_pend[i]) m_act[i] = m_shd[i];
        m_pend[i] = 1'b0;
        m_cnt[i] = '0;
        m_clk[i] = 1'b0;
        m_stb[i] = 1'b0;
      end else if (m_cnt[i] == m_act[i]) begin
        if (m_pend[i]) m_act[i] = m_shd[i];
        m_pend[i] = 1'b0;
        m_cnt[i] = '0;
        m_clk[i] = ~m_clk[i];
        m_stb[i] = 1'b1;
      end else begin
        m_cnt[i] = m_cnt[i] + 1'b1;
        m_stb[i] = 1'b0;
      end
      if (bus.wr_en && int'(bus.wr_ch) == i) begin
        m_shd[i] = bus.wr_div;
        m_pend[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    sb.push_back({m_clk, m_stb, m_pend});
    @(posedge clk_in);
    #1;
  endtask

  task automatic wtick(input int ch, input int d);
    bus.wr_en = 1'b1;
    bus.wr_ch = CW'(ch);
    bus.wr_div = W'(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  always @(posedge clk_in) begin : monitor
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.clk_out, bus.stb, bus.pending} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got clk=%b stb=%b pend=%b exp clk=%b stb=%b pend=%b",
                 $time, bus.clk_out, bus.stb, bus.pending, e.clk, e.stb, e.pend);
      end
    end
  end

  task automatic test_reset();
    checks++;
    if ({bus.clk_out, bus.stb, bus.pending} !== '0) begin
      errors++;
      $display("FAIL reset_state got %b exp 0", {bus.clk_out, bus.stb, bus.pending});
    end
    rst = 1'b0;
  endtask

  task automatic test_div2();
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (bus.stb !== 4'hF || bus.clk_out !== ((k % 2) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL div2 k=%0d got clk=%b stb=%b", k, bus.clk_out, bus.stb);
      end
    end
  endtask

  task automatic test_write_ch1();
    int last = 0;
    int high = 0;
    wtick(1, 4);
    checks++;
    if (bus.pending[1] !== 1'b1) begin
      errors++;
      $display("FAIL wr_pending got %b exp 1", bus.pending[1]);
    end
    tick();
    checks++;
    if (bus.pending[1] !== 1'b0 || bus.stb[1] !== 1'b1) begin
      errors++;
      $display("FAIL wr_apply got pend=%b stb=%b exp 0 1", bus.pending[1], bus.stb[1]);
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      high += int'(bus.clk_out[1]);
      checks++;
      if (bus.stb[1] !== (k % 5 == 0)) begin
        errors++;
        $display("FAIL div5_stb k=%0d got %b last=%0d", k, bus.stb[1], last);
      end
      if (bus.stb[1]) last = k;
    end
    checks++;
    if (high != 10) begin
      errors++;
      $display("FAIL div5_duty got %0d high cycles exp 10", high);
    end
  endtask

  task automatic test_terminal_write();
    wtick(2, 6);
    wtick(2, 3);
    checks++;
    if (bus.pending[2] !== 1'b1 || bus.stb[2] !== 1'b1) begin
      errors++;
      $display("FAIL tc_write got pend=%b stb=%b exp 1 1", bus.pending[2], bus.stb[2]);
    end
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (bus.stb[2] !== (k == 7 || k == 11 || k == 15) || bus.pending[2] !== (k < 7)) begin
        errors++;
        $display("FAIL tc_halves k=%0d got stb=%b pend=%b", k, bus.stb[2], bus.pending[2]);
      end
    end
  endtask

  task automatic test_sync();
    wtick(0, 2);
    wtick(3, 2);
    repeat (4) tick();
    bus.sync = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_ch = CW'(1);
    bus.wr_div = W'(1);
    tick();
    bus.sync = 1'b0;
    bus.wr_en = 1'b0;
    checks++;
    if (bus.clk_out !== 4'h0 || bus.stb !== 4'h0 || bus.pending !== 4'b0010) begin
      errors++;
      $display("FAIL sync_clear got clk=%b stb=%b pend=%b", bus.clk_out, bus.stb, bus.pending);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (bus.clk_out[0] !== ((k / 3) % 2 == 1) || bus.clk_out[3] !== bus.clk_out[0]) begin
        errors++;
        $display("FAIL sync_align k=%0d got ch0=%b ch3=%b", k, bus.clk_out[0], bus.clk_out[3]);
      end
    end
  endtask

  task automatic test_bad_channel();
    wtick(4, 7);
    checks++;
    if (bus.pending !== 4'h0) begin
      errors++;
      $display("FAIL bad_channel got pend=%b exp 0000", bus.pending);
    end
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    wtick(1, 9);
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.clk_out, bus.stb, bus.pending} !== '0) begin
      errors++;
      $display("FAIL async_reset got %b exp 0", {bus.clk_out, bus.stb, bus.pending});
    end
    model_reset();
    #1 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (bus.stb !== 4'hF || bus.pending !== 4'h0 || bus.clk_out !== ((k % 2) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL post_reset k=%0d got clk=%b stb=%b pend=%b", k, bus.clk_out, bus.stb, bus.pending);
      end
    end
  endtask

  task automatic test_disable();
    wtick(1, 9);
    tick();
    wtick(1, 3);
    bus.en[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (bus.clk_out[1] !== 1'b0 || bus.stb[1] !== 1'b0 || bus.pending[1] !== 1'b0) begin
        errors++;
        $display("FAIL disable k=%0d got clk=%b stb=%b pend=%b", k, bus.clk_out[1], bus.stb[1], bus.pending[1]);
      end
    end
    bus.en[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (bus.clk_out[1] !== (k == 4) || bus.stb[1] !== (k == 4)) begin
        errors++;
        $display("FAIL reenable k=%0d got clk=%b stb=%b", k, bus.clk_out[1], bus.stb[1]);
      end
    end
  endtask

  task automatic test_max_div();
    wtick(0, 15);
    tick();
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++;
      if (bus.stb[0] !== (k == 16 || k == 32) || bus.clk_out[0] !== (k < 16 || k == 32)) begin
        errors++;
        $display("FAIL max_div k=%0d got clk=%b stb=%b", k, bus.clk_out[0], bus.stb[0]);
      end
    end
  endtask

  initial begin
    bus.en = '0;
    bus.sync = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_ch = '0;
    bus.wr_div = '0;
    model_reset();
    #2 bus.en = 4'hF;
    @(posedge clk_in);
    #1;
    test_reset();
    test_div2();
    test_write_ch1();
    test_terminal_write();
    test_sync();
    test_bad_channel();
    test_async_reset();
    test_disable();
    test_max_div();
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
